// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one dmem port between the CPU (c_*) and a debug/DMA requester (d_*).
// Ports: clock/reset; c_req/c_addr/c_wdata/c_op/c_we in, c_gnt/c_rvalid out; d_req/d_lock/d_addr/d_wdata/d_op/d_we in,
// d_gnt/d_rvalid out; rdata (mirrors m_dataout); m_addr/m_datain/m_op/m_we to dmem, m_dataout from dmem; c_wait_cnt stall counter.
module dmem_arbiter #(
   parameter int MAX_BURST = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        c_req,
   input  logic [31:0] c_addr,
   input  logic [31:0] c_wdata,
   input  logic [2:0]  c_op,
   input  logic        c_we,
   output logic        c_gnt,
   output logic        c_rvalid,
   input  logic        d_req,
   input  logic        d_lock,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [2:0]  d_op,
   input  logic        d_we,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] rdata,
   output logic [31:0] m_addr,
   output logic [31:0] m_datain,
   output logic [2:0]  m_op,
   output logic        m_we,
   input  logic [31:0] m_dataout,
   output logic [15:0] c_wait_cnt
);
   localparam logic [7:0] MAXB = 8'(MAX_BURST);
   logic       last_owner, d_prev, rd_valid, rd_owner, d_win, hold;
   logic [7:0] burst_cnt;
   always_comb begin
      hold     = d_lock && d_prev && (burst_cnt < MAXB);
      d_win    = d_req && (!c_req || hold || !last_owner);
      d_gnt    = !reset && d_win;
      c_gnt    = !reset && c_req && !d_win;
      m_addr   = d_gnt ? d_addr  : c_gnt ? c_addr  : '0;
      m_datain = d_gnt ? d_wdata : c_gnt ? c_wdata : '0;
      m_op     = d_gnt ? d_op    : c_gnt ? c_op    : '0;
      m_we     = d_gnt ? d_we    : c_gnt ? c_we    : 1'b0;
      // reset gates the response so a read granted just before reset never completes
      c_rvalid = !reset && rd_valid && !rd_owner;
      d_rvalid = !reset && rd_valid && rd_owner;
      rdata    = m_dataout;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         last_owner <= 1'b1;
         d_prev     <= 1'b0;
         burst_cnt  <= '0;
         rd_valid   <= 1'b0;
         rd_owner   <= 1'b0;
         c_wait_cnt <= '0;
      end else begin
         if (c_gnt || d_gnt) last_owner <= d_gnt;
         d_prev     <= d_gnt;
         burst_cnt  <= (d_gnt && d_lock) ? ((burst_cnt >= MAXB) ? MAXB : burst_cnt + 8'd1) : '0;
         rd_valid   <= (c_gnt || d_gnt) && !m_we;
         rd_owner   <= d_gnt;
         if (c_req && !c_gnt && c_wait_cnt != 16'hFFFF) c_wait_cnt <= c_wait_cnt + 16'd1;
      end
   end
endmodule
